// File: rtl/regfile_scoreboard_pkg.sv
// rtl/regfile_scoreboard_pkg.sv - shared sizing constants for the register file and its scoreboard
//
// Purpose: default data width, register count, register-address width and the
// hardwired-zero register index, shared by decode, writeback and the register
// file itself.
// Ports: none (package).
package regfile_scoreboard_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int REG_AW    = $clog2(NREGS_DEF);
  localparam int ZERO_REG  = 0;

endpackage : regfile_scoreboard_pkg

// File: rtl/regfile_scoreboard_scoreboard_bits.sv
// rtl/regfile_scoreboard_scoreboard_bits.sv - per-register pending-write busy flags
//
// Purpose: one busy flop per architectural register. A set (issue) and a clear
// (writeback) may arrive in the same cycle; when both name the same register
// the set wins, because the new instruction's write is still outstanding.
// Entry 0 is never busy.
// Ports:
//   clk      in   clock
//   reset    in   asynchronous active-low reset, clears every flag
//   set_en   in   mark set_idx busy at the next edge
//   set_idx  in   register being issued
//   clr_en   in   mark clr_idx idle at the next edge
//   clr_idx  in   register being written back
//   busy     out  current busy flags, one per register
module scoreboard_bits
  import regfile_scoreboard_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en,
  input  logic [AW-1:0]    set_idx,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_idx,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    // applied after the clear so a same-register issue leaves the flag set
    if (set_en) busy_d[set_idx] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule : scoreboard_bits

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - integer register file with pending-write scoreboard
//
// Purpose: NREGS x XLEN register file (register 0 hardwired to zero) with two
// combinational read ports, one clocked writeback port and an issue port that
// marks the destination busy until its writeback lands. issue_ready stalls on
// RAW (either source busy) and WAW (destination busy) hazards and never looks
// at issue_valid.
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle writeback
// onto the read ports and mask the matching busy/stall terms.
// Ports:
//   clk                  in   clock
//   reset                in   asynchronous active-low reset
//   rs1_addr, rs2_addr   in   read addresses
//   rs1_data, rs2_data   out  read data (combinational)
//   rs1_busy, rs2_busy   out  source has a pending write
//   issue_valid          in   decode wants to issue an instruction writing issue_rd
//   issue_rd             in   destination of the issuing instruction
//   issue_ready          out  issue accepted this cycle
//   wb_valid             in   writeback strobe
//   wb_rd                in   writeback destination
//   wb_data              in   writeback value
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ready,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic             wb_en;
  logic             fire;
  logic             rd_busy;

  assign wb_en = wb_valid && (wb_rd != ZERO_IDX);
  assign fire  = issue_valid && issue_ready;

  // entry 0 is cleared by reset and never written, so it always reads zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_rd] <= wb_data;
    end
  end

  scoreboard_bits #(
    .NREGS (NREGS)
  ) u_scoreboard_bits (
    .clk     (clk),
    .reset   (reset),
    .set_en  (fire),
    .set_idx (issue_rd),
    .clr_en  (wb_en),
    .clr_idx (wb_rd),
    .busy    (busy)
  );

  always_comb begin
    rs1_data = regs[rs1_addr];
    rs2_data = regs[rs2_addr];
    rs1_busy = busy[rs1_addr];
    rs2_busy = busy[rs2_addr];
    rd_busy  = busy[issue_rd];
`ifdef REGFILE_BYPASS_EN
    // a landing writeback resolves the hazard in the cycle it arrives
    if (wb_en && (wb_rd == rs1_addr)) begin
      rs1_data = wb_data;
      rs1_busy = 1'b0;
    end
    if (wb_en && (wb_rd == rs2_addr)) begin
      rs2_data = wb_data;
      rs2_busy = 1'b0;
    end
    if (wb_en && (wb_rd == issue_rd)) rd_busy = 1'b0;
`endif
  end

  assign issue_ready = !(rs1_busy || rs2_busy || rd_busy);

endmodule : regfile_scoreboard

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised integer register file with a per-register pending-write scoreboard, replacing the two-entry, two-read-port register pair in the ID stage. It provides two combinational read ports, one clocked writeback port and an issue port that marks destination registers busy until their writeback lands. Decode uses it to detect RAW/WAW hazards and stall issue. Register 0 is hardwired to zero, per RISC-V.

## Interface
Parameters:
- XLEN, 32, data width of every register.
- NREGS, 32, number of architectural registers (power of two, ≥2); AW = log2(NREGS) is derived, not overridable.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all registers and busy bits immediately.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- rs1_data  out  XLEN  contents of rs1_addr (combinational).
- rs2_data  out  XLEN  contents of rs2_addr (combinational).
- rs1_busy  out  1  rs1_addr has a pending write.
- rs2_busy  out  1  rs2_addr has a pending write.
- issue_valid  in  1  decode wants to issue an instruction writing issue_rd.
- issue_rd  in  AW  destination of the issuing instruction.
- issue_ready  out  1  issue is accepted this cycle.
- wb_valid  in  1  writeback strobe.
- wb_rd  in  AW  writeback destination.
- wb_data  in  XLEN  writeback value.

## Operation
- Storage: NREGS × XLEN registers plus NREGS busy bits; entry 0 always reads 0 and is never busy, and writes/issues to 0 are ignored.
- Read: rsN_data = reg[rsN_addr]; rsN_busy = busy[rsN_addr].
- Hazard: stall = rs1_busy | rs2_busy | busy[issue_rd]; issue_ready = ~stall. issue_ready is independent of issue_valid (no combinational loop).
- Issue fire = issue_valid & issue_ready: busy[issue_rd] set at next edge (if issue_rd ≠ 0).
- Writeback (wb_valid, wb_rd ≠ 0): reg[wb_rd] ← wb_data and busy[wb_rd] cleared at next edge. A writeback to a non-busy register still writes.
- Simultaneous fire and writeback to same rd: write occurs and busy ends set (set beats clear).
- Simultaneous fire and writeback to different registers: both take effect.
- Reset asserted mid-operation: all contents 0, all busy 0, regardless of in-flight issue/wb; state holds while reset is low.

## Timing
- Reset values: rs1_data = rs2_data = 0, rs1_busy = rs2_busy = 0, issue_ready = 1.
- Read latency 0 cycles (combinational from addresses and state).
- Write latency 1 cycle: data written at edge N is visible on the read ports after edge N (bypass case below excepted).
- Busy set by a fire at edge N is visible after edge N; with WAW blocking there is at most one pending write per register, so one bit suffices.

## Configuration
- REGFILE_BYPASS_EN defined: when wb_valid and wb_rd == rsN_addr ≠ 0, rsN_data = wb_data and rsN_busy = 0 in the same cycle; the stall term busy[issue_rd] is likewise masked by a matching writeback. Gives zero-bubble writeback-to-decode forwarding.
- Not defined: reads return stored state only; a consumer of wb_rd stalls one extra cycle until the write lands.

## Structure
- Shared package: XLEN default, NREGS default, register-address width constant, and the ZERO_REG index constant, for use by decode and writeback stages.
- One natural sub-module: scoreboard_bits (NREGS busy flops with set/clear priority and zero-entry masking); data storage and read muxing stay in the top.

## Test plan
- Reset low mid-run after writing reg 5 = 0xDEADBEEF → rs1_addr=5 reads 0, all busy 0, issue_ready = 1 while low and after release.
- Write reg 0 with 0x1234 and issue to rd 0 → reads 0, rs busy 0, issue_ready stays 1.
- Issue rd=7, then next cycle issue_valid with rs1_addr=7 → issue_ready = 0 until wb_rd=7 data 0xA5A5A5A5; after the write edge, rs1_data = 0xA5A5A5A5, issue_ready = 1.
- Issue rd=3 while wb_valid to rd=3 same cycle → reg 3 updated, busy[3] = 1 afterwards.
- With REGFILE_BYPASS_EN: busy reg 9, rs2_addr=9, wb_rd=9 data 0x55 → same cycle rs2_data = 0x55, rs2_busy = 0, issue_ready = 1; without the macro rs2_busy = 1 and issue_ready = 0 that cycle.
- NREGS=8, XLEN=16: write all 7 nonzero regs with their index × 0x1111 → each reads back correctly on both ports.
